lif_array_scheduler: RTL
========================

# lif_array_scheduler

Time-multiplexed controller for the spiking reservoir. It shares one LIF update datapath across NUM_NEURONS neurons whose membrane voltages live in a local register file. Each start strobe latches one 32-bit rate-coded frame from the bitstream converter, which is downstream of the NARMA generator. The block then sequences one neuron update per clock and returns the frame's spike vector with a done pulse.

## Interface
- NUM_NEURONS, 8, neurons served; must divide IN_WIDTH
- IN_WIDTH, 32, frame width; each neuron gets BPN = IN_WIDTH/NUM_NEURONS bits
- VTH, 32'h0000fc93, firing threshold, signed Q16.16 (0.98)
- LEAK, 32'h00002000, per-frame leak, Q16.16 (0.125)
- WEIGHT, 32'h00002000, weight per active input bit, Q16.16 (0.125)
- REFRAC_FRAMES, 1, frames a neuron is held after firing (1..15)
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  frame strobe; sampled only in IDLE
- bitstream_in  input  IN_WIDTH  frame; neuron n uses bits [n*BPN +: BPN]
- busy  output  1  high from the cycle after accepted start until DONE exits
- done  output  1  one-cycle pulse; spike_vec valid in the same cycle
- spike_vec  output  NUM_NEURONS  bit n = neuron n fired this frame; held until the next done
- overrun  output  1  sticky; set when start is seen while not IDLE
- v_rd_addr  input  $clog2(NUM_NEURONS)  debug read index
- v_rd_data  output  32  combinational read of membrane[v_rd_addr]

## Operation
- FSM states are IDLE, UPDATE and DONE.
- IDLE + start:
  - latch bitstream_in into frame_q
  - set idx = 0 and clear spike accumulator
  - go to UPDATE
- UPDATE handles neuron idx each cycle:
  - a = popcount(frame_q[idx*BPN +: BPN]) * WEIGHT (unsigned count, 32-bit signed product)
  - a > 0: v' = v + a, saturating at 32'h7fffffff
  - a == 0 and v > 0: v' = v - LEAK, clamped to 0 if negative
  - otherwise v' = v
  - v' >= VTH (signed compare): spike bit idx = 1 and store 0; otherwise store v'
  - idx == NUM_NEURONS-1: go to DONE; otherwise idx++
- DONE:
  - done = 1, spike_vec <= accumulator, busy = 0 next cycle
  - go to IDLE
- start in UPDATE or DONE is ignored and sets overrun. overrun clears only on reset.
- Reset values: state IDLE, busy 0, done 0, spike_vec 0, overrun 0, all membranes 0, all refractory counters 0, frame_q 0.
- reset asserted mid-UPDATE aborts the frame: no done, partial updates are discarded because the register file is cleared.
- Membrane values are never negative.

## Timing
- Start accepted at edge k.
- UPDATE occupies edges k+1 .. k+NUM_NEURONS.
- done is high during the cycle after edge k+NUM_NEURONS+1; default latency is 9 clocks.
- Back-to-back throughput: a new start can be accepted in the IDLE cycle after done, giving one frame per NUM_NEURONS+2 cycles.
- One register-file write per cycle, no read-after-write hazard: each index is touched once per frame.
- v_rd_data reflects writes from the previous edge.

## Configuration
- LIF_SCHED_REFRAC_EN defined:
  - each neuron has a 4-bit refractory counter, loaded with REFRAC_FRAMES when it fires
  - in UPDATE, a neuron with counter > 0 ignores input, holds v = 0, never spikes, and decrements its counter
- Undefined:
  - no counters; a fired neuron integrates normally in the next frame
  - REFRAC_FRAMES is unused

## Structure
- lif_sched_pkg holds:
  - state enum (IDLE, UPDATE, DONE)
  - Q16.16 default constants
  - popcount function
  - saturating-add function
- One sub-module, lif_update_unit: purely combinational; (v, bits, refrac_cnt) -> (v_next, spike, refrac_next).
- The scheduler owns the FSM, index counter, register file and output registers.

## Test plan
- Reset, then read all 8 addresses: v_rd_data = 0 everywhere; busy, done, spike_vec and overrun all 0.
- Two frames of 32'hFFFFFFFF:
  - frame 1: every v = 0x00008000, spike_vec = 8'h00
  - frame 2: 0x10000 >= VTH, so spike_vec = 8'hFF and all v = 0
  - done arrives exactly 9 cycles after each start
- Frame 32'h00000001, then frame 32'h0: neuron 0 goes to v = 0x2000, then 0 (leak clamp); the other neurons stay 0.
- With LIF_SCHED_REFRAC_EN and REFRAC_FRAMES = 1, send three frames of all ones:
  - frame 2 gives spike_vec = 8'hFF
  - frame 3 leaves v = 0 with no spike (refractory)
  - frame 4 gives v = 0x8000
  - without the macro, frame 3 gives v = 0x8000
- start pulsed 3 cycles after an accepted start: ignored, overrun = 1, still exactly one done.
- reset asserted at UPDATE idx = 4: no done; afterwards all v = 0 and state IDLE; the next start completes normally.

Source files
------------

// File: rtl/lif_sched_pkg.sv
// Shared types, Q16.16 defaults and arithmetic helpers for the LIF array scheduler.
// Refractory support is enabled by defining LIF_SCHED_REFRAC_EN.
package lif_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } sched_state_t;

    localparam int          DEF_NUM_NEURONS   = 8;
    localparam int          DEF_IN_WIDTH      = 32;
    localparam logic [31:0] DEF_VTH           = 32'h0000fc93;
    localparam logic [31:0] DEF_LEAK          = 32'h00002000;
    localparam logic [31:0] DEF_WEIGHT        = 32'h00002000;
    localparam int          DEF_REFRAC_FRAMES = 1;
    localparam logic [31:0] V_MAX             = 32'h7fffffff;

    function automatic logic [31:0] popcount(input logic [31:0] bits);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'b0, bits[i]};
        end
        return n;
    endfunction

    // Both operands are non-negative, so a 33-bit sum cannot wrap.
    function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [31:0] a);
        logic [32:0] s;
        s = {1'b0, v} + {1'b0, a};
        if (s > {1'b0, V_MAX}) begin
            return V_MAX;
        end
        return s[31:0];
    endfunction

endpackage

// File: rtl/lif_update_unit.sv
// Combinational single-neuron LIF step: integrate or leak, threshold, refractory hold.
// Refractory input is tied to zero by the scheduler unless LIF_SCHED_REFRAC_EN is defined.
module lif_update_unit
    import lif_sched_pkg::*;
#(
    parameter int          BPN           = 4,
    parameter logic [31:0] VTH           = DEF_VTH,
    parameter logic [31:0] LEAK          = DEF_LEAK,
    parameter logic [31:0] WEIGHT        = DEF_WEIGHT,
    parameter int          REFRAC_FRAMES = DEF_REFRAC_FRAMES
) (
    input  logic [31:0]    v,
    input  logic [BPN-1:0] bits,
    input  logic [3:0]     refrac_cnt,
    output logic [31:0]    v_next,
    output logic           spike,
    output logic [3:0]     refrac_next
);

    logic [31:0] bits_ext;
    logic [31:0] a;
    logic [31:0] v_leak;
    logic [31:0] v_int;

    always_comb begin
        bits_ext    = 32'(bits);
        a           = popcount(bits_ext) * WEIGHT;
        v_leak      = v - LEAK;
        v_int       = v;
        v_next      = '0;
        spike       = 1'b0;
        refrac_next = '0;

        if ($signed(a) > 0) begin
            v_int = sat_add(v, a);
        end else if ($signed(v) > 0) begin
            v_int = ($signed(v_leak) < 0) ? '0 : v_leak;
        end

        if (refrac_cnt != 4'd0) begin
            refrac_next = refrac_cnt - 4'd1;
        end else if ($signed(v_int) >= $signed(VTH)) begin
            spike       = 1'b1;
            refrac_next = 4'(REFRAC_FRAMES);
        end else begin
            v_next = v_int;
        end
    end

endmodule

// File: rtl/lif_array_scheduler.sv
// Time-multiplexed LIF controller: one shared update datapath sweeps NUM_NEURONS membranes per frame.
// Define LIF_SCHED_REFRAC_EN to add per-neuron refractory counters.
//
// state  | meaning
// IDLE   | waiting for start; accepts a frame and clears the spike accumulator
// UPDATE | updates neuron idx, one per clock
// DONE   | publishes spike_vec with a done pulse, drops busy
module lif_array_scheduler
    import lif_sched_pkg::*;
#(
    parameter int          NUM_NEURONS   = DEF_NUM_NEURONS,
    parameter int          IN_WIDTH      = DEF_IN_WIDTH,
    parameter logic [31:0] VTH           = DEF_VTH,
    parameter logic [31:0] LEAK          = DEF_LEAK,
    parameter logic [31:0] WEIGHT        = DEF_WEIGHT,
    parameter int          REFRAC_FRAMES = DEF_REFRAC_FRAMES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [IN_WIDTH-1:0]            bitstream_in,
    output logic                           busy,
    output logic                           done,
    output logic [NUM_NEURONS-1:0]         spike_vec,
    output logic                           overrun,
    input  logic [$clog2(NUM_NEURONS)-1:0] v_rd_addr,
    output logic [31:0]                    v_rd_data
);

    localparam int BPN   = IN_WIDTH / NUM_NEURONS;
    localparam int IDX_W = $clog2(NUM_NEURONS);

    sched_state_t           state;
    logic [IDX_W-1:0]       idx;
    logic [IN_WIDTH-1:0]    frame_q;
    logic [NUM_NEURONS-1:0] acc;
    logic [31:0]            membrane [NUM_NEURONS];

    logic [BPN-1:0] cur_bits;
    logic [31:0]    cur_v;
    logic [3:0]     cur_refrac;
    logic [31:0]    v_next;
    logic           spike;
    logic [3:0]     refrac_next;

    assign cur_bits  = frame_q[int'(idx)*BPN +: BPN];
    assign cur_v     = membrane[idx];
    assign v_rd_data = membrane[v_rd_addr];

`ifdef LIF_SCHED_REFRAC_EN
    logic [3:0] refrac_q [NUM_NEURONS];
    assign cur_refrac = refrac_q[idx];
`else
    logic refrac_unused;
    assign cur_refrac    = 4'd0;
    assign refrac_unused = ^refrac_next;
`endif

    lif_update_unit #(
        .BPN           (BPN),
        .VTH           (VTH),
        .LEAK          (LEAK),
        .WEIGHT        (WEIGHT),
        .REFRAC_FRAMES (REFRAC_FRAMES)
    ) u_update (
        .v           (cur_v),
        .bits        (cur_bits),
        .refrac_cnt  (cur_refrac),
        .v_next      (v_next),
        .spike       (spike),
        .refrac_next (refrac_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            frame_q   <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            spike_vec <= '0;
            overrun   <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                membrane[i] <= '0;
`ifdef LIF_SCHED_REFRAC_EN
                refrac_q[i] <= '0;
`endif
            end
        end else begin
            done <= 1'b0;
            if (start && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        frame_q <= bitstream_in;
                        idx     <= '0;
                        acc     <= '0;
                        busy    <= 1'b1;
                        state   <= UPDATE;
                    end
                end
                UPDATE: begin
                    membrane[idx] <= v_next;
                    acc[idx]      <= spike;
`ifdef LIF_SCHED_REFRAC_EN
                    refrac_q[idx] <= refrac_next;
`endif
                    if (idx == IDX_W'(NUM_NEURONS - 1)) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    done      <= 1'b1;
                    spike_vec <= acc;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
